// File: rtl/cpu6_timer.sv
// cpu6_timer: memory-mapped 64-bit machine timer with prescaler, compare register and level interrupt
module cpu6_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataaddr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sel,
  output logic        tmr_irq_r
);
  logic [63:0] mtime, mtimecmp, mtime_inc;
  logic [7:0]  div, pcnt;
  logic [3:0]  off;
  logic        en, we, wr_ctrl, tick, unused;
  assign sel       = dataaddr[31:6] == BASE_ADDR[31:6];
  assign off       = dataaddr[5:2];
  assign we        = memwrite && sel;
  assign wr_ctrl   = we && off == 4'h4;
  assign tick      = en && pcnt == div && !wr_ctrl;
  assign mtime_inc = mtime + {63'd0, tick};
  assign unused    = ^dataaddr[1:0];
  // each half takes its own write; the other half keeps the incremented value, so a LO write still carries into HI
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      en        <= 1'b0;
      div       <= '0;
      pcnt      <= '0;
      tmr_irq_r <= 1'b0;
    end else begin
      pcnt           <= (wr_ctrl || !en || pcnt == div) ? 8'd0 : pcnt + 8'd1;
      mtime[31:0]    <= (we && off == 4'h0) ? writedata : mtime_inc[31:0];
      mtime[63:32]   <= (we && off == 4'h1) ? writedata : mtime_inc[63:32];
      mtimecmp[31:0] <= (we && off == 4'h2) ? writedata : mtimecmp[31:0];
      mtimecmp[63:32] <= (we && off == 4'h3) ? writedata : mtimecmp[63:32];
      en             <= wr_ctrl ? writedata[0] : en;
      div            <= wr_ctrl ? writedata[15:8] : div;
      tmr_irq_r      <= mtime >= mtimecmp;
    end
  end
  always_comb begin
    readdata = '0;
    if (sel)
      case (off)
        4'h0:    readdata = mtime[31:0];
        4'h1:    readdata = mtime[63:32];
        4'h2:    readdata = mtimecmp[31:0];
        4'h3:    readdata = mtimecmp[63:32];
        4'h4:    readdata = {16'd0, div, 7'd0, en};
        4'h5:    readdata = {31'd0, tmr_irq_r};
        default: readdata = '0;
      endcase
  end
endmodule
